// File: rtl/dpcm_decoder.sv
// DMC rate decoder and sample-period timer: Fx selects an NTSC period (FR),
// and a 9-bit down-counter emits one registered tick per FR cycles.
module dpcm_decoder (
  input  logic       CLK,
  input  logic       nRES,
  input  logic [3:0] Fx,
  input  logic       load,
  output logic [8:0] FR,
  output logic       tick,
  output logic [8:0] cnt
);

  always_comb begin
    FR = 9'h0D6;
    case (Fx)
      4'd0:  FR = 9'h0D6;
      4'd1:  FR = 9'h0BE;
      4'd2:  FR = 9'h0AA;
      4'd3:  FR = 9'h0A0;
      4'd4:  FR = 9'h08F;
      4'd5:  FR = 9'h07F;
      4'd6:  FR = 9'h071;
      4'd7:  FR = 9'h06B;
      4'd8:  FR = 9'h05F;
      4'd9:  FR = 9'h050;
      4'd10: FR = 9'h047;
      4'd11: FR = 9'h040;
      4'd12: FR = 9'h035;
      4'd13: FR = 9'h02A;
      4'd14: FR = 9'h024;
      4'd15: FR = 9'h01B;
      default: FR = 9'h0D6;
    endcase
  end

  logic cnt_zero;
  assign cnt_zero = (cnt == 9'd0);

  // Reload on terminal count gives exactly FR edges between ticks; a load
  // wins over a coincident terminal count and swallows that tick.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      cnt  <= 9'd0;
      tick <= 1'b0;
    end else begin
      if (load || cnt_zero) cnt <= FR - 9'd1;
      else                  cnt <= cnt - 9'd1;
      tick <= cnt_zero && !load;
    end
  end

endmodule

// File: tb/tb_dpcm_decoder.sv
// Scoreboard bench for dpcm_decoder: expected tick cycles are queued when
// stimulus is applied and matched against observed ticks.
module tb_dpcm_decoder;
  logic       CLK = 1'b0;
  logic       nRES;
  logic [3:0] Fx;
  logic       load;
  logic [8:0] FR;
  logic       tick;
  logic [8:0] cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];
  int base;

  dpcm_decoder dut (
    .CLK(CLK), .nRES(nRES), .Fx(Fx), .load(load),
    .FR(FR), .tick(tick), .cnt(cnt)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Advance negedge by negedge, matching every observed tick to the queue head.
  task automatic watch_until(input int target);
    int e;
    while (cyc < target) begin
      @(negedge CLK);
      if (tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick at cycle %0d got tick=1 required 0", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin
            errors++;
            $display("FAIL tick_cycle got %0d required %0d", cyc, e);
          end
        end
      end
    end
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_ticks got %0d pending required 0 (next %0d)",
               name, exp_q.size(), exp_q[0]);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    nRES = 1'b0; load = 1'b0; Fx = 4'd0;
    repeat (3) @(negedge CLK);
    checks++;
    if (cnt !== 9'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d tick=%b required cnt=0 tick=0", cnt, tick);
    end
  endtask

  task automatic test_fx_sweep();
    logic [8:0] tbl [16];
    tbl = '{9'h0D6, 9'h0BE, 9'h0AA, 9'h0A0, 9'h08F, 9'h07F, 9'h071, 9'h06B,
            9'h05F, 9'h050, 9'h047, 9'h040, 9'h035, 9'h02A, 9'h024, 9'h01B};
    for (int i = 0; i < 16; i++) begin
      Fx = i[3:0];
      #1;
      checks++;
      if ($isunknown(FR) || FR !== tbl[i]) begin
        errors++;
        $display("FAIL fr_decode Fx=%0d got %h required %h", i, FR, tbl[i]);
      end
    end
  endtask

  task automatic test_fx15_free_run();
    int c0;
    logic [8:0] exp_cnt;
    Fx = 4'd15;
    @(negedge CLK);
    nRES = 1'b1;
    c0 = cyc;
    exp_q.push_back(c0 + 1);
    exp_q.push_back(c0 + 28);
    exp_q.push_back(c0 + 55);
    while (cyc < c0 + 56) begin
      watch_until(cyc + 1);
      exp_cnt = 9'(26 - ((cyc - c0 - 1) % 27));
      checks++;
      if (cnt !== exp_cnt) begin
        errors++;
        $display("FAIL fx15_cnt at cycle %0d got %0d required %0d", cyc, cnt, exp_cnt);
      end
    end
    drain_check("fx15");
  endtask

  task automatic test_fx0_period();
    Fx = 4'd0;
    load = 1'b1;
    base = cyc + 1;
    watch_until(base);
    load = 1'b0;
    checks++;
    if (cnt !== 9'd213) begin
      errors++;
      $display("FAIL load_reload got %0d required 213", cnt);
    end
    exp_q.push_back(base + 214);
    exp_q.push_back(base + 428);
    watch_until(base + 528);
    drain_check("fx0");
  endtask

  task automatic test_fx_change();
    Fx = 4'd15;
    exp_q.push_back(base + 642);
    exp_q.push_back(base + 669);
    exp_q.push_back(base + 696);
    watch_until(base + 642);
    checks++;
    if (cnt !== 9'd26) begin
      errors++;
      $display("FAIL fx_change_reload got %0d required 26", cnt);
    end
    watch_until(base + 700);
    drain_check("fx_change");
  endtask

  task automatic test_load_at_zero();
    int z;
    for (int i = 0; i < 40 && cnt != 9'd0; i++) watch_until(cyc + 1);
    checks++;
    if (cnt !== 9'd0) begin
      errors++;
      $display("FAIL load_zero_wait got cnt=%0d required 0 within 40 cycles", cnt);
    end
    load = 1'b1;
    z = cyc;
    watch_until(z + 1);
    load = 1'b0;
    checks++;
    if (cnt !== 9'd26 || tick !== 1'b0) begin
      errors++;
      $display("FAIL load_at_zero got cnt=%0d tick=%b required cnt=26 tick=0", cnt, tick);
    end
    exp_q.push_back(z + 28);
    watch_until(z + 35);
    drain_check("load_at_zero");
  endtask

  task automatic test_reset_mid();
    int r;
    @(posedge CLK);
    #2;
    nRES = 1'b0;
    #1;
    checks++;
    if (cnt !== 9'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got cnt=%0d tick=%b required cnt=0 tick=0", cnt, tick);
    end
    repeat (3) @(negedge CLK);
    nRES = 1'b1;
    r = cyc;
    exp_q.push_back(r + 1);
    exp_q.push_back(r + 28);
    exp_q.push_back(r + 55);
    watch_until(r + 1);
    checks++;
    if (cnt !== 9'd26) begin
      errors++;
      $display("FAIL reset_release_cnt got %0d required 26", cnt);
    end
    watch_until(r + 60);
    drain_check("reset_mid");
  endtask

  initial begin
    test_reset();
    test_fx_sweep();
    test_fx15_free_run();
    test_fx0_period();
    test_fx_change();
    test_load_at_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
